spi_regmap_ctrlr: RTL
=====================

// Module: spi_regmap_ctrlr
// PURPOSE
//  Parametrised byte-command register controller behind the SPI byte MMIO port (successor to ctrlr).
//  Decodes {rd, addr[6:0]} command bytes and serves chip-ID, switch, LED and error-status registers.
//  Adds frame-delimited transactions, burst auto-increment (optional) and access-error counting.
// PARAMETERS
//  SW_BYTES   2      number of 8-bit switch registers (1..8)
//  LED_BYTES  2      number of 8-bit LED registers (1..8)
//  CHIP_ID    8'h07  value returned at address 0x00
// PORTS
//  clk       in   1              system clock; one clock, all logic on posedge
//  rst       in   1              reset; asynchronous and active-low (0 = reset)
//  switches  in   8*SW_BYTES     raw switch inputs, asynchronous to clk
//  leds      out  8*LED_BYTES    LED register contents
//  frame     in   1              high while a transaction (SPI CS) is active
//  new_data  in   1              one-cycle strobe: din holds a received byte
//  din       in   8              received byte
//  dout      out  8              byte to shift out on the next transfer
//  err_cnt   out  8              saturating count of illegal accesses
// BEHAVIOUR
//  Map: 0x00 CHIP_ID (RO); 0x01..SW_BYTES switches, LSB first (RO); next LED_BYTES addrs LEDs (RW);
//   next addr STATUS = err_cnt (RO); all higher addrs unmapped.
//  Reset (rst=0, async): leds=0, dout=0, err_cnt=0, FSM=CMD, addr=0, switch sync flops=0.
//  FSM CMD: new_data && frame -> latch rd=din[7], addr=din[6:0]; go DATA.
//   rd=1: dout <= rdata(addr) on the cycle after the strobe (1-cycle latency).
//   rd=0: dout unchanged.
//  FSM DATA: new_data && frame -> byte accepted:
//   rd=0: write din to addr if LED addr, visible on leds the cycle after the strobe.
//   rd=1: din is a dummy byte and is ignored.
//   Next state is set by CTRLR_BURST_EN (see CONFIGURATION).
//  frame low: FSM forced to CMD that cycle; a new_data coincident with frame low is dropped.
//  Errors: write to RO/unmapped addr or read of unmapped addr -> ignored, err_cnt+1, saturates at 8'hFF.
//   Unmapped reads return 8'h00.
//  Address increment wraps 7'h7F -> 7'h00.
//  Switch reads return the 2-flop-synchronised value; effective input latency is 2 clk.
//  new_data asserted on consecutive cycles is legal; each strobe is one byte.
//  Reset mid-transaction aborts it; no partial write.
// CONFIGURATION
//  CTRLR_BURST_EN defined: DATA stays in DATA and addr increments after each accepted byte.
//   Reads preload dout <= rdata(addr+1) the cycle after each dummy byte.
//   Writes go to successive addresses. Transaction ends only on frame low.
//  CTRLR_BURST_EN undefined: DATA returns to CMD after one accepted byte (legacy cmd/data alternation).
//   frame may be tied high.
// STRUCTURE
//  ctrlr_pkg: state_t enum {CMD, DATA}, RD_BIT=7, ADDR_CHIP_ID=7'h00, ADDR_SW_BASE=7'h01,
//   function addr_led_base(SW_BYTES), function addr_status(SW_BYTES,LED_BYTES).
//  Sub-module sync_2ff #(WIDTH) for the switch inputs; decode/readmux/FSM stay in the top.
// TESTING (frame=1 unless stated)
//  Chip ID: cmd 0x80 then dummy 0x00, twice -> dout==8'h07 after each dummy.
//  Switches: switches=16'h00FF, wait 3 clk; read 0x81 -> 8'hFF; read 0x82 -> 8'h00.
//  LEDs: write 0x03/0xFF, 0x04/0xAA -> leds==16'hAAFF; read 0x83 -> 8'hFF, 0x84 -> 8'hAA;
//   write 0x00 to both -> leds==0.
//  Errors: write 0x01/0x55, read 0xFF -> dout==0, err_cnt==2, leds/switch values unchanged.
//   256 more bad writes -> err_cnt==8'hFF.
//  Burst (CTRLR_BURST_EN): one frame with 0x03,0x12,0x34 -> leds==16'h3412; frame low;
//   new frame with 0x83 plus 2 dummies -> dout 8'h12 then 8'h34.
//   Without macro: the 0x34 byte is taken as a command.
//  Abort: pull frame low after cmd 0x03 -> next byte 0x84 treated as cmd, leds unchanged.
//   rst=0 mid-write -> leds==0 immediately (async), FSM=CMD.

Source files
------------

// File: rtl/spi_regmap_ctrlr_pkg.sv
// Shared types and address-map helpers for the SPI byte register controller.
// Used by spi_regmap_ctrlr; the burst option is selected there with CTRLR_BURST_EN.
package ctrlr_pkg;

    // Command/data phase of a byte transaction
    typedef enum logic [0:0] {
        CMD  = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int         RD_BIT       = 7;
    localparam logic [6:0] ADDR_CHIP_ID = 7'h00;
    localparam logic [6:0] ADDR_SW_BASE = 7'h01;

    // First LED address: directly after the switch registers
    function automatic logic [6:0] addr_led_base(input int sw_bytes);
        return ADDR_SW_BASE + 7'(sw_bytes);
    endfunction

    // Status (error counter) address: directly after the LED registers
    function automatic logic [6:0] addr_status(input int sw_bytes, input int led_bytes);
        return addr_led_base(sw_bytes) + 7'(led_bytes);
    endfunction

endpackage

// File: rtl/spi_regmap_ctrlr_sync_2ff.sv
// Two-flop synchroniser for quasi-static inputs (switch bank).
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_regmap_ctrlr.sv
// Byte-command register controller behind the SPI byte MMIO port.
// Command byte {rd, addr[6:0]} followed by data bytes; serves chip ID,
// synchronised switches, LED registers and a saturating error counter.
// Optional feature macro: CTRLR_BURST_EN (burst auto-increment within a frame).
module spi_regmap_ctrlr
    import ctrlr_pkg::*;
#(
    parameter int         SW_BYTES  = 2,
    parameter int         LED_BYTES = 2,
    parameter logic [7:0] CHIP_ID   = 8'h07
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*SW_BYTES-1:0]  switches,
    output logic [8*LED_BYTES-1:0] leds,
    input  logic                   frame,
    input  logic                   new_data,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [7:0]             err_cnt
);

    localparam logic [6:0] LED_BASE    = addr_led_base(SW_BYTES);
    localparam logic [6:0] STATUS_ADDR = addr_status(SW_BYTES, LED_BYTES);

    logic [8*SW_BYTES-1:0] sw_sync;
    state_t                state;
    logic                  rd_q;
    logic [6:0]            addr_q;

    logic                  cmd_take;
    logic                  data_take;
    logic                  cmd_rd;
    logic [6:0]            cmd_addr;
    logic [6:0]            addr_inc;
    logic                  wr_ok;
    logic                  wr_err;
    logic                  rd_err;
    logic                  err_evt;

    sync_2ff #(
        .WIDTH(8*SW_BYTES)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (switches),
        .q   (sw_sync)
    );

    // Read mux over the whole map; unmapped addresses read as zero
    function automatic logic [7:0] rdata(
        input logic [6:0]             a,
        input logic [8*SW_BYTES-1:0]  sw,
        input logic [8*LED_BYTES-1:0] ld,
        input logic [7:0]             ec
    );
        logic [7:0] r;
        r = 8'h00;
        if (a == ADDR_CHIP_ID) r = CHIP_ID;
        for (int i = 0; i < SW_BYTES; i++)
            if (a == ADDR_SW_BASE + 7'(i)) r = sw[8*i +: 8];
        for (int i = 0; i < LED_BYTES; i++)
            if (a == LED_BASE + 7'(i)) r = ld[8*i +: 8];
        if (a == STATUS_ADDR) r = ec;
        return r;
    endfunction

    function automatic logic readable(input logic [6:0] a);
        return a <= STATUS_ADDR;
    endfunction

    function automatic logic is_led(input logic [6:0] a);
        return (a >= LED_BASE) && (a < STATUS_ADDR);
    endfunction

    assign cmd_take  = new_data && frame && (state == CMD);
    assign data_take = new_data && frame && (state == DATA);
    assign cmd_rd    = din[RD_BIT];
    assign cmd_addr  = din[6:0];
    assign addr_inc  = addr_q + 7'd1;

    assign wr_ok  = data_take && !rd_q &&  is_led(addr_q);
    assign wr_err = data_take && !rd_q && !is_led(addr_q);
`ifdef CTRLR_BURST_EN
    // A burst read preloads the next address, so that access can fault too
    assign rd_err = (cmd_take && cmd_rd && !readable(cmd_addr)) ||
                    (data_take && rd_q && !readable(addr_inc));
`else
    assign rd_err = cmd_take && cmd_rd && !readable(cmd_addr);
`endif
    assign err_evt = wr_err || rd_err;

    // Transaction FSM: frame low always returns to the command phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= CMD;
            rd_q   <= 1'b0;
            addr_q <= 7'h00;
        end else if (!frame) begin
            state  <= CMD;
        end else if (new_data) begin
            case (state)
                CMD: begin
                    rd_q   <= cmd_rd;
                    addr_q <= cmd_addr;
                    state  <= DATA;
                end
                DATA: begin
`ifdef CTRLR_BURST_EN
                    addr_q <= addr_inc;
                    state  <= DATA;
`else
                    state  <= CMD;
`endif
                end
                default: state <= CMD;
            endcase
        end
    end

    // Outgoing byte: loaded on a read command (and on each burst dummy byte)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 8'h00;
        end else if (cmd_take && cmd_rd) begin
            dout <= rdata(cmd_addr, sw_sync, leds, err_cnt);
`ifdef CTRLR_BURST_EN
        end else if (data_take && rd_q) begin
            dout <= rdata(addr_inc, sw_sync, leds, err_cnt);
`endif
        end
    end

    // LED register writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LED_BYTES; i++)
                if (addr_q == LED_BASE + 7'(i)) leds[8*i +: 8] <= din;
        end
    end

    // Saturating count of illegal accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 8'h00;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
